// File: rtl/scale_accum_pipe.sv
// Scale-and-accumulate block: each sample is scaled by a fixed-point coefficient,
// thresholded, and summed with saturation over blocks of BLOCK_LEN samples.
module scale_accum_pipe #(
    parameter int DATA_W    = 32,
    parameter int SCALE_W   = 16,
    parameter int FRAC_W    = 8,
    parameter int SCALE     = 384,
    parameter int THRESHOLD = 2,
    parameter int BLOCK_LEN = 4,
    parameter int ACC_W     = 48,
    parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int PROD_W = DATA_W + SCALE_W;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  smp_q, smp_d;
    logic              sat_q, sat_d;

    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] scaled;
    logic [SUM_W-1:0]  sum_wide;
    logic              pass;
    logic              clip;
    logic              accept;
    logic              last_smp;

    assign product  = PROD_W'(in_data) * PROD_W'(SCALE);
    assign scaled   = product >> FRAC_W;
    assign pass     = scaled > PROD_W'(THRESHOLD);
    // One spare bit above the wider operand catches any overflow past ACC_W.
    assign sum_wide = SUM_W'(acc_q) + SUM_W'(scaled);
    assign clip     = |sum_wide[SUM_W-1:ACC_W];

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid & in_ready;
    assign last_smp = ((smp_q + 1'b1) == CNT_W'(BLOCK_LEN));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        smp_d   = smp_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    smp_d = smp_q + 1'b1;
                    if (pass) begin
                        cnt_d = cnt_q + 1'b1;
                        if (clip) begin
                            acc_d = '1;
                            sat_d = 1'b1;
                        end else begin
                            acc_d = sum_wide[ACC_W-1:0];
                        end
                    end
                    state_d = (last_smp || flush) ? DONE : ACCUM;
                end else if (flush && (state_q == ACCUM)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    smp_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            smp_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            sat_q   <= sat_d;
        end
    end

    // Result fields are forced to zero whenever no result is being presented.
    assign out_valid = rst_n && (state_q == DONE);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_count = out_valid ? cnt_q : '0;
    assign out_sat   = out_valid ? sat_q : 1'b0;

endmodule

// File: tb/tb_scale_accum_pipe.sv
// Scoreboard bench for scale_accum_pipe: directed scenarios followed by random traffic,
// checked against a block-level arithmetic model.
module tb_scale_accum_pipe;
    localparam int DATA_W    = 32;
    localparam int SCALE_W   = 16;
    localparam int FRAC_W    = 8;
    localparam int SCALE     = 384;
    localparam int THRESHOLD = 2;
    localparam int BLOCK_LEN = 4;
    localparam int ACC_W     = 34;
    localparam int CNT_W     = $clog2(BLOCK_LEN + 1);
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    typedef struct {
        longint unsigned data;
        int unsigned     count;
        bit              sat;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready;

    int total;
    int bad;

    exp_t        sb[$];
    int unsigned blk[$];
    bit          holding;

    scale_accum_pipe #(
        .DATA_W(DATA_W), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W), .SCALE(SCALE),
        .THRESHOLD(THRESHOLD), .BLOCK_LEN(BLOCK_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: sum of floor(x*SCALE/2^FRAC_W) over samples above threshold, clamped.
    function automatic exp_t model_block();
        exp_t e;
        longint unsigned x;
        longint unsigned sc;
        e.data = 0;
        e.count = 0;
        e.sat = 1'b0;
        foreach (blk[k]) begin
            x  = blk[k];
            sc = (x * SCALE) >> FRAC_W;
            if (sc > THRESHOLD) begin
                e.count++;
                e.data += sc;
                if (e.data > ACC_MAX) begin
                    e.data = ACC_MAX;
                    e.sat  = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input bit f, input bit ordy);
        bit   acc;
        bit   close;
        exp_t e;
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        #1;
        total++;
        if (in_ready !== !holding) begin
            bad++;
            $display("FAIL in_ready t=%0t got=%0b want=%0b", $time, in_ready, !holding);
        end
        total++;
        if (out_valid !== holding) begin
            bad++;
            $display("FAIL out_valid t=%0t got=%0b want=%0b", $time, out_valid, holding);
        end
        acc = v && !holding;
        if (acc) blk.push_back(d);
        close = !holding && ((acc && ((blk.size() == BLOCK_LEN) || f)) ||
                             (!acc && f && (blk.size() > 0)));
        if (holding && ordy) holding = 1'b0;
        if (close) begin
            e = model_block();
            sb.push_back(e);
            $display("block closed: samples=%0d exp_data=%0d exp_count=%0d exp_sat=%0b",
                     blk.size(), e.data, e.count, e.sat);
            blk.delete();
            holding = 1'b1;
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_out got_valid=%0b got_data=%0d want 0/0", out_valid, out_data);
        end
        blk.delete();
        if (holding) begin
            void'(sb.pop_back());
            holding = 1'b0;
        end
    endtask

    // Monitor: compares every presented result with the scoreboard head, pops on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result got_data=%0d want none", out_data);
                end else begin
                    e = sb[0];
                    if (longint'(out_data) != e.data || int'(out_count) != e.count ||
                        out_sat != e.sat) begin
                        bad++;
                        $display("FAIL result got data=%0d count=%0d sat=%0b want data=%0d count=%0d sat=%0b",
                                 out_data, out_count, out_sat, e.data, e.count, e.sat);
                    end else if (out_ready) begin
                        $display("result ok: data=%0d count=%0d sat=%0b", out_data, out_count, out_sat);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                total++;
                if (out_data !== '0 || out_count !== '0 || out_sat !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_zero got data=%0d count=%0d sat=%0b want 0",
                             out_data, out_count, out_sat);
                end
            end
        end
    end

    initial begin
        int unsigned r;
        logic [31:0] d;
        total     = 0;
        bad       = 0;
        holding   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) reset_cycle();

        // Basic block: 4,1,2,10 -> 24, count 3
        step(1, 4, 0, 1); step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 10, 0, 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);

        // Back-pressure: result held for 5 cycles while a sample waits
        step(1, 8, 0, 0); step(1, 8, 0, 0); step(1, 8, 0, 0); step(1, 8, 0, 0);
        repeat (5) step(1, 3, 0, 0);
        step(1, 3, 0, 1);
        step(1, 3, 0, 1); step(1, 3, 0, 1); step(1, 3, 0, 1); step(1, 3, 0, 1);
        step(0, 0, 0, 1);

        // Early flush with the 2nd sample, then flush alone in idle
        step(1, 4, 0, 1); step(1, 4, 1, 1); step(0, 0, 0, 1);
        step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);

        // Single-sample block closed by flush in idle
        step(1, 20, 1, 1); step(0, 0, 0, 1);

        // Saturation
        repeat (4) step(1, 32'hFFFF_FFFF, 0, 1);
        step(0, 0, 0, 1);

        // Reset mid-block discards partial data
        step(1, 9, 0, 1); step(1, 9, 0, 1);
        reset_cycle();
        step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 5, 0, 1);
        step(0, 0, 0, 1);

        // All samples at or below threshold
        step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
        step(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      d = 32'hFFFF_FFFF - $urandom_range(0, 1000);
            else if (r < 4) d = $urandom;
            else            d = $urandom_range(0, 12);
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6);
        end

        // Drain any open block and pending results
        for (int i = 0; i < 30 && (sb.size() != 0 || holding || blk.size() != 0); i++)
            step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        total++;
        if (sb.size() != 0 || holding || blk.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
